// File: rtl/v16_pulse_gen.sv
// v16_pulse_gen: synthetic ADC pulse source for exercising a shaping filter.
// A start request arms a fixed delay. The latched amplitude is then injected
// into a fixed-point accumulator, which decays exponentially by
// (1 - 2^-TAU_SHIFT) every cycle. A new start during the decay tail piles a
// second pulse on top of the decaying one.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      pulse request, sampled every edge
//   amplitude  pulse height in LSB, latched when start is accepted
//   adc_data   registered sample: BASELINE + integer part of acc, saturated
//   busy       high whenever the FSM is not in IDLE
//   pulse_mark one-cycle strobe, high while adc_data first shows a new pulse
//   drop       one-cycle strobe, high the cycle after an ignored start
//
// state  | meaning
// IDLE   | accumulator held at zero, waiting for start
// DELAY  | counting down to injection, tail keeps decaying
// INJECT | one cycle: add the latched amplitude into the decaying accumulator
// DECAY  | free decay; returns to IDLE once the next decay step reaches zero
module v16_pulse_gen #(
  parameter int DATA_W    = 12,
  parameter int FRAC_W    = 8,
  parameter int TAU_SHIFT = 4,
  parameter int DELAY_CYC = 3,
  parameter int BASELINE  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] amplitude,
  output logic [DATA_W-1:0] adc_data,
  output logic              busy,
  output logic              pulse_mark,
  output logic              drop
);

  localparam int ACC_W = DATA_W + FRAC_W;
  localparam int DATA_MAX_I = (1 << DATA_W) - 1;
  localparam logic [ACC_W-1:0]  ACC_MAX  = '1;
  localparam logic [DATA_W-1:0] DATA_MAX = '1;
  // BASELINE is pre-saturated so the output adder only needs one carry bit.
  localparam logic [DATA_W-1:0] BASE_SAT =
    (BASELINE > DATA_MAX_I) ? DATA_W'(DATA_MAX_I) : DATA_W'(BASELINE);
  localparam logic [7:0] DELAY_LOAD = 8'(DELAY_CYC - 1);

  typedef enum logic [1:0] {IDLE, DELAY, INJECT, DECAY} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_next, acc_shr;
  logic [ACC_W:0]    amp_ext, inj_sum;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] amp_q, amp_d;
  logic [DATA_W:0]   out_sum;
  logic [DATA_W-1:0] adc_next;
  logic              start_ign;

  // Once the decrement truncates to zero the residue is flushed, so the tail
  // always terminates instead of sticking at a small nonzero value.
  always_comb begin
    acc_shr = acc_q >> TAU_SHIFT;
    acc_d   = (acc_shr == '0) ? '0 : acc_q - acc_shr;
    amp_ext = {1'b0, amp_q, {FRAC_W{1'b0}}};
    inj_sum = {1'b0, acc_d} + amp_ext;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    amp_d     = amp_q;
    acc_next  = acc_d;
    start_ign = 1'b0;
    case (state_q)
      IDLE: begin
        acc_next = '0;
        if (start) begin
          state_d = DELAY;
          amp_d   = amplitude;
          cnt_d   = DELAY_LOAD;
        end
      end
      DELAY: begin
        start_ign = start;
        if (cnt_q == 8'd0) state_d = INJECT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      INJECT: begin
        start_ign = start;
        acc_next  = inj_sum[ACC_W] ? ACC_MAX : inj_sum[ACC_W-1:0];
        state_d   = DECAY;
      end
      DECAY: begin
        if (start) begin
          state_d = DELAY;
          amp_d   = amplitude;
          cnt_d   = DELAY_LOAD;
        end else if (acc_d == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        acc_next = '0;
      end
    endcase
  end

  always_comb begin
    out_sum  = {1'b0, BASE_SAT} + {1'b0, acc_next[ACC_W-1:FRAC_W]};
    adc_next = out_sum[DATA_W] ? DATA_MAX : out_sum[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= 8'd0;
      amp_q      <= '0;
      adc_data   <= BASE_SAT;
      pulse_mark <= 1'b0;
      drop       <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_next;
      cnt_q      <= cnt_d;
      amp_q      <= amp_d;
      adc_data   <= adc_next;
      pulse_mark <= (state_q == INJECT);
      drop       <= start_ign;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_v16_pulse_gen.sv
// Testbench for v16_pulse_gen (default parameters). Stimulus pushes
// cycle-tagged expectations and expected pulse peaks; a negedge monitor
// compares them against the DUT.
module tb_v16_pulse_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] amplitude;
  logic [11:0] adc_data;
  logic        busy;
  logic        pulse_mark;
  logic        drop;

  v16_pulse_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .amplitude  (amplitude),
    .adc_data   (adc_data),
    .busy       (busy),
    .pulse_mark (pulse_mark),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  localparam int K_ADC  = 0;
  localparam int K_BUSY = 1;
  localparam int K_PM   = 2;
  localparam int K_DROP = 3;
  localparam int K_PEND = 4;

  typedef struct {
    int          tgt;
    int          kind;
    int          val;
    logic [63:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   peak_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // k = 0 refers to the state right after the most recent rising edge.
  function automatic void exp_at(int k, int kind, int val, logic [63:0] tag);
    exp_t e;
    e.tgt  = cyc + k;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    exp_q.push_back(e);
  endfunction

  // Monitor: peak check on every pulse_mark, plus cycle-tagged expectations.
  always @(negedge clk) begin
    int act;
    int pk;
    if (pulse_mark) begin
      checks++;
      if (peak_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: pulse_mark=1 adc_data=%0d, expected no pulse", adc_data);
      end else begin
        pk = peak_q.pop_front();
        if (int'(adc_data) != pk) begin
          failures++;
          $display("FAIL peak: adc_data=%0d expected=%0d (cycle %0d)", adc_data, pk, cyc);
        end
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].tgt == cyc) begin
        case (exp_q[i].kind)
          K_ADC:   act = int'(adc_data);
          K_BUSY:  act = int'(busy);
          K_PM:    act = int'(pulse_mark);
          K_DROP:  act = int'(drop);
          default: act = peak_q.size();
        endcase
        checks++;
        if (act != exp_q[i].val) begin
          failures++;
          $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", exp_q[i].tag, act, exp_q[i].val, cyc);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    exp_at(0, K_BUSY, 0, "idle");
    exp_at(0, K_ADC, 0, "idle_adc");
  endtask

  task automatic fire(int amp, int peak);
    amplitude = 12'(amp);
    start     = 1'b1;
    peak_q.push_back(peak);
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    amplitude = 12'd0;
    tick();
    tick();
    exp_at(0, K_ADC, 0, "rst_adc");
    exp_at(0, K_BUSY, 0, "rst_busy");
    exp_at(0, K_PM, 0, "rst_pm");
    exp_at(0, K_DROP, 0, "rst_drop");
    // reset wins over start
    start     = 1'b1;
    amplitude = 12'd700;
    tick();
    exp_at(0, K_BUSY, 0, "rst_prio");
    exp_at(0, K_ADC, 0, "rstp_adc");
    start = 1'b0;
    reset = 1'b0;
    tick();

    // single pulse, then pile-up from adc_data=878
    fire(1000, 1000);
    exp_at(0, K_BUSY, 1, "busy_e");
    exp_at(0, K_ADC, 0, "dly_e0");
    exp_at(1, K_ADC, 0, "dly_e1");
    exp_at(2, K_ADC, 0, "dly_e2");
    exp_at(3, K_ADC, 0, "dly_e3");
    exp_at(3, K_PM, 0, "pm_e3");
    exp_at(4, K_PM, 1, "pm_e4");
    exp_at(4, K_ADC, 1000, "pk_e4");
    exp_at(5, K_ADC, 937, "dec_e5");
    exp_at(5, K_PM, 0, "pm_e5");
    exp_at(6, K_ADC, 878, "dec_e6");
    repeat (6) tick();
    fire(500, 1136);
    exp_at(0, K_DROP, 0, "pile_nod");
    exp_at(0, K_ADC, 823, "pile_e0");
    exp_at(1, K_ADC, 772, "pile_e1");
    exp_at(2, K_ADC, 724, "pile_e2");
    exp_at(3, K_ADC, 678, "pile_e3");
    exp_at(4, K_PM, 1, "pile_pm");
    exp_at(5, K_ADC, 1065, "pile_e5");
    repeat (5) tick();
    wait_idle(400);
    tick();

    // start one cycle after an accepted start is dropped
    fire(300, 300);
    amplitude = 12'd2000;
    start     = 1'b1;
    tick();
    start = 1'b0;
    exp_at(0, K_DROP, 1, "drop_set");
    exp_at(1, K_DROP, 0, "drop_clr");
    exp_at(3, K_ADC, 300, "drop_pk");
    repeat (4) tick();
    exp_at(0, K_PM, 0, "drop_pm0");
    wait_idle(400);
    tick();

    // zero amplitude still runs the full sequence
    fire(0, 0);
    exp_at(4, K_PM, 1, "z_pm");
    exp_at(4, K_BUSY, 1, "z_busy");
    exp_at(5, K_BUSY, 0, "z_idle");
    exp_at(5, K_ADC, 0, "z_adc");
    repeat (5) tick();
    tick();

    // saturation via pile-up of two full-scale pulses
    fire(4095, 4095);
    repeat (4) tick();
    exp_at(0, K_ADC, 4095, "sat_p1");
    fire(4095, 4095);
    exp_at(0, K_ADC, 3839, "sat_dec");
    exp_at(4, K_ADC, 4095, "sat_p2");
    exp_at(5, K_ADC, 3840, "sat_tail");
    repeat (5) tick();
    wait_idle(400);
    tick();

    // reset in the middle of a decay, then a clean pulse
    fire(1000, 1000);
    repeat (6) tick();
    exp_at(0, K_ADC, 878, "pre_rst");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_at(0, K_ADC, 0, "mrst_adc");
    exp_at(0, K_BUSY, 0, "mrst_bsy");
    exp_at(0, K_PM, 0, "mrst_pm");
    exp_at(0, K_DROP, 0, "mrst_drp");
    fire(1000, 1000);
    exp_at(3, K_ADC, 0, "r_e3");
    exp_at(4, K_ADC, 1000, "r_e4");
    exp_at(5, K_ADC, 937, "r_e5");
    exp_at(6, K_ADC, 878, "r_e6");
    repeat (6) tick();
    wait_idle(400);
    tick();

    // unit amplitude tail must decay to exactly zero
    fire(1, 1);
    exp_at(4, K_ADC, 1, "tail_pk");
    exp_at(5, K_ADC, 0, "tail_e5");
    exp_at(5, K_BUSY, 1, "tail_bsy");
    repeat (5) tick();
    wait_idle(100);
    tick();

    exp_at(0, K_PEND, 0, "pend_pk");
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/v16_pulse_gen.md
V16_PULSE_GEN -- requirements
Module: v16_pulse_gen

Interface
REQ-001 Parameter DATA_W, default 12, width of the generated ADC sample.
REQ-002 Parameter FRAC_W, default 8, fractional bits of the internal decay accumulator.
REQ-003 Parameter TAU_SHIFT, default 4, decay shift; per-cycle decay factor is (1 - 2^-TAU_SHIFT).
REQ-004 Parameter DELAY_CYC, default 3, range 1..255, cycles from start acceptance to pulse injection.
REQ-005 Parameter BASELINE, default 0, constant offset added to every output sample.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  pulse request, sampled on each rising edge.
REQ-009 amplitude  input  DATA_W  pulse height in LSB, latched when start is accepted.
REQ-010 adc_data  output  DATA_W  registered synthetic ADC sample stream feeding the filter input.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 pulse_mark  output  1  one-cycle strobe, high in the cycle adc_data first shows an injected pulse.
REQ-013 drop  output  1  one-cycle strobe, high the cycle after an ignored start.

Function
REQ-014 FSM states SHALL be IDLE, DELAY, INJECT, DECAY.
REQ-015 Accumulator acc SHALL be unsigned, DATA_W+FRAC_W bits; integer part = acc >> FRAC_W.
REQ-016 Decay step SHALL be acc_d = acc - (acc >> TAU_SHIFT); if (acc >> TAU_SHIFT) == 0, acc_d = 0.
REQ-017 Decay step SHALL apply every cycle in DELAY, INJECT and DECAY; in IDLE, acc holds 0.
REQ-018 IDLE with start=1 -> DELAY; amplitude latched; delay counter loaded with DELAY_CYC-1.
REQ-019 DELAY SHALL decrement the counter each cycle and go to INJECT on the cycle it reads 0.
REQ-020 INJECT SHALL, for exactly one cycle, set acc <= acc_d + (amp_latched << FRAC_W), clamped to 2^(DATA_W+FRAC_W)-1; next state DECAY.
REQ-021 DECAY with start=1 -> DELAY (pile-up); amplitude latched; decay continues.
REQ-022 DECAY with start=0 and acc_d == 0 -> IDLE.
REQ-023 start in DELAY or INJECT SHALL be ignored and SHALL assert drop for one cycle.
REQ-024 adc_data SHALL be registered as min(BASELINE + (acc_next >> FRAC_W), 2^DATA_W-1), updated on the same edge as acc.
REQ-025 pulse_mark SHALL be high for the single cycle after the INJECT edge.
REQ-026 Latency: start sampled at edge E; peak visible on adc_data after edge E+DELAY_CYC+1.
REQ-027 amplitude=0 SHALL run the full FSM sequence and assert pulse_mark, adding nothing to acc.

Reset
REQ-028 reset=1 at a rising edge SHALL force state IDLE, acc=0, counter=0, latched amplitude=0.
REQ-029 During reset, adc_data SHALL be BASELINE (saturated to 2^DATA_W-1), and busy, pulse_mark and drop SHALL be 0.
REQ-030 reset SHALL take priority over start in any state, including mid-pulse.
REQ-031 start is sampled normally on the first edge with reset=0.

Verification (defaults unless stated)
REQ-032 Single pulse: amplitude=1000, start at edge E.
  -> adc_data=0 through E+3; 1000 with pulse_mark=1 after E+4; 937 after E+5; 878 after E+6; busy drops once acc reaches 0.
REQ-033 Pile-up: second start (amplitude=500) while in DECAY with adc_data=878.
  -> injection 4 cycles later adds 500 onto the decayed value; pulse_mark strobes again.
REQ-034 Dropped request: start asserted 1 cycle after an accepted start.
  -> drop=1 for one cycle; exactly one pulse_mark; no extra amplitude added.
REQ-035 Saturation: amplitude=4095 injected twice via pile-up.
  -> acc clamps; adc_data holds 4095 and never wraps.
REQ-036 Reset mid-DECAY: reset=1 for one cycle.
  -> next cycle adc_data=0, busy=0; a subsequent start behaves as in REQ-032.
REQ-037 Tail termination: amplitude=1, TAU_SHIFT=4.
  -> acc reaches exactly 0 and FSM returns to IDLE within a bounded cycle count; no stall at a nonzero residue.
